// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width default and
// the baud divider constants used by the baud generator, this receiver
// and the transmitter.
package uart_rx_frame_pkg;

    // Default number of data bits per frame (8N1 framing).
    localparam int UART_DATA_BITS = 8;

    // System clock and line rate the divider constants are derived from.
    localparam int CLK_HZ    = 50_000_000;
    localparam int BAUD_RATE = 115_200;

    // Clocks per bit, and the offset of the bit centre within a bit.
    localparam int BPS_FULL  = CLK_HZ / BAUD_RATE;
    localparam int BPS_HALF  = BPS_FULL / 2;

    // Receiver state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Bit counter width: one extra bit so the counter can hold DATA_BITS
    // itself after the last shift without wrapping.
    function automatic int bit_cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_frame_sync_fall_detect.sv
// Metastability synchroniser for an asynchronous, idle-high line, followed
// by a falling-edge detector. All flops reset to 1 so a line that is idle
// at reset release never produces a spurious edge.
module sync_fall_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_sync,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    // First synchroniser stage captures the raw asynchronous line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync[0] <= 1'b1;
        end else begin
            r_sync[0] <= i_din;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_sync
            // Each further stage re-times the previous one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync[gi] <= 1'b1;
                end else begin
                    r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    // History flop holds the previous synchronised value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_fall = r_hist & ~r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// Frame-level UART receiver. Detects a start edge, requests the baud
// generator, samples DATA_BITS data bits LSB first at each bit-centre
// strobe, then checks the stop bit and reports either a good byte or a
// framing error with a one-cycle pulse.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rs232_rx,
    input  logic                 i_clk_bps,
    output logic                 o_bps_start,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_frame_err,
    output logic                 o_rx_busy
);

    localparam int CW = bit_cnt_width(DATA_BITS);

    logic                 w_rx_s;
    logic                 w_fall;
    logic [DATA_BITS-1:0] w_shift_next;

    rx_state_t            r_state;
    logic [CW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_bps_start;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_rx_busy;

    // Only the synchronised line is ever sampled; the raw pin never reaches
    // the FSM.
    sync_fall_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (i_rs232_rx),
        .o_sync (w_rx_s),
        .o_fall (w_fall)
    );

    // New bits enter at the MSB so the first (least significant) bit ends
    // up in bit 0 after DATA_BITS shifts.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign w_shift_next = w_rx_s;
        end else begin : g_shift_many
            assign w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

    // Receiver FSM; all outputs are registered and the pulses default low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_bps_start <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Strobes seen here are stale and ignored; only an edge
                    // starts a frame.
                    if (w_fall) begin
                        r_state     <= ST_START;
                        r_bps_start <= 1'b1;
                        r_rx_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (i_clk_bps) begin
                        if (w_rx_s) begin
                            // Line high again at start-bit centre: glitch.
                            r_state     <= ST_IDLE;
                            r_bps_start <= 1'b0;
                            r_rx_busy   <= 1'b0;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_clk_bps) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_clk_bps) begin
                        if (w_rx_s) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        // Leaving at stop-bit centre leaves half a bit to
                        // catch the next start edge; dropping the request
                        // also clears the baud counter.
                        r_state     <= ST_IDLE;
                        r_bps_start <= 1'b0;
                        r_rx_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_bps_start <= 1'b0;
                    r_rx_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_bps_start = r_bps_start;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_rx_busy   = r_rx_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: a behavioural baud generator plus a frame-level
// transmitter drive the receiver; expectations come from the frame rules
// (good stop bit -> byte delivered, bad stop bit -> one error, aborted or
// glitched frames -> nothing).
module tb_uart_rx_frame;
    import uart_rx_frame_pkg::*;

    localparam int DB = 8;
    localparam int SS = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          rs232_rx  = 1'b1;
    logic          force_bps = 1'b0;
    logic          clk_bps;
    logic          bps_start;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          rx_busy;

    int unsigned   baud_cnt;
    int            total = 0;
    int            bad   = 0;
    int            n_valid = 0;
    int            n_err   = 0;
    int            n_both  = 0;
    logic [DB-1:0] got_q[$];
    logic [DB-1:0] exp_data;

    uart_rx_frame #(
        .DATA_BITS   (DB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rs232_rx  (rs232_rx),
        .i_clk_bps   (clk_bps),
        .o_bps_start (bps_start),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_frame_err (frame_err),
        .o_rx_busy   (rx_busy)
    );

    always #10 clk = ~clk;

    // Baud generator model: counts while enabled, strobes at bit centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            baud_cnt <= 0;
        else if (!bps_start)
            baud_cnt <= 0;
        else
            baud_cnt <= (baud_cnt == BPS_FULL - 1) ? 0 : baud_cnt + 1;
    end
    assign clk_bps = (bps_start && baud_cnt == BPS_HALF) || force_bps;

    // Pulse monitor: counts every high cycle of each pulse output.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            got_q.push_back(rx_data);
        end
        if (frame_err) n_err++;
        if (rx_valid && frame_err) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialise one frame: start, data LSB first, stop. abort_bit >= 0
    // pulses reset in the middle of that data bit and abandons the frame.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b,
                              input int abort_bit, output int lat);
        logic [DB+1:0] bits;
        bits = {stop_b, d, 1'b0};
        lat  = -1;
        for (int b = 0; b < DB + 2; b++) begin
            rs232_rx = bits[b];
            for (int c = 1; c <= BPS_FULL; c++) begin
                @(posedge clk);
                #1;
                if (b == 0 && lat < 0 && bps_start) lat = c;
                if (abort_bit >= 0 && b == abort_bit + 1 && c == BPS_HALF) begin
                    rst_n    = 1'b0;
                    rs232_rx = 1'b1;
                    #1;
                    chk("abort_bps_start", bps_start, 0);
                    chk("abort_busy", rx_busy, 0);
                    chk("abort_rx_data", rx_data, 0);
                    exp_data = '0;
                    tick(3);
                    rst_n = 1'b1;
                    return;
                end
            end
        end
    endtask

    // Send one frame and check the frame-level outcome, then idle for gap.
    task automatic run_frame(input logic [DB-1:0] d, input logic stop_b,
                             input int gap, input string tag);
        int v0, e0, lat;
        logic [31:0] g;
        v0 = n_valid;
        e0 = n_err;
        send_frame(d, stop_b, -1, lat);
        chk({tag, "_bps_rise"}, lat, SS + 1);
        if (stop_b) begin
            chk({tag, "_valid_cnt"}, n_valid - v0, 1);
            chk({tag, "_err_cnt"}, n_err - e0, 0);
            g = 32'hDEAD;
            if (got_q.size() > 0) g = {24'd0, got_q.pop_front()};
            chk({tag, "_data"}, g, {24'd0, d});
            exp_data = d;
        end else begin
            chk({tag, "_valid_cnt"}, n_valid - v0, 0);
            chk({tag, "_err_cnt"}, n_err - e0, 1);
        end
        got_q.delete();
        chk({tag, "_rx_data"}, rx_data, exp_data);
        chk({tag, "_bps_end"}, bps_start, 0);
        chk({tag, "_busy_end"}, rx_busy, 0);
        rs232_rx = 1'b1;
        tick(gap);
    endtask

    initial begin
        int v0, e0, lat, gap;
        logic [DB-1:0] d;
        logic sb;

        exp_data = '0;
        tick(3);
        chk("rst_bps_start", bps_start, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        tick(5);

        run_frame(8'hA5, 1'b1, 2 * BPS_FULL, "a5");

        // Short low glitch: start is rejected at the first strobe.
        v0 = n_valid; e0 = n_err;
        rs232_rx = 1'b0;
        tick(50);
        chk("glitch_bps_on", bps_start, 1);
        tick(50);
        rs232_rx = 1'b1;
        tick(BPS_FULL);
        chk("glitch_bps_off", bps_start, 0);
        chk("glitch_busy", rx_busy, 0);
        chk("glitch_valid", n_valid - v0, 0);
        chk("glitch_err", n_err - e0, 0);
        chk("glitch_rx_data", rx_data, exp_data);

        // Bad stop bit, line then held low: exactly one error.
        v0 = n_valid; e0 = n_err;
        send_frame(8'h3C, 1'b0, -1, lat);
        chk("e3c_bps_rise", lat, SS + 1);
        tick(2 * BPS_FULL);
        chk("e3c_err_cnt", n_err - e0, 1);
        chk("e3c_valid_cnt", n_valid - v0, 0);
        chk("e3c_rx_data", rx_data, exp_data);
        chk("e3c_bps_held_low", bps_start, 0);
        rs232_rx = 1'b1;
        tick(BPS_FULL);
        got_q.delete();

        // Back-to-back frames with no idle gap.
        run_frame(8'h00, 1'b1, 0, "b2b_00");
        run_frame(8'hFF, 1'b1, 0, "b2b_ff");
        run_frame(8'h55, 1'b1, BPS_FULL, "b2b_55");

        // Reset during data bit 4 of 0x81, then a clean frame.
        v0 = n_valid; e0 = n_err;
        send_frame(8'h81, 1'b1, 4, lat);
        tick(2 * BPS_FULL);
        chk("abort_valid", n_valid - v0, 0);
        chk("abort_err", n_err - e0, 0);
        chk("abort_rx_data_after", rx_data, 0);
        chk("abort_bps_after", bps_start, 0);
        got_q.delete();
        run_frame(8'h42, 1'b1, BPS_FULL, "r42");

        // Strobe forced while idle: must be ignored.
        v0 = n_valid; e0 = n_err;
        for (int i = 0; i < 5; i++) begin
            force_bps = 1'b1;
            tick(1);
            chk("idle_bps_start", bps_start, 0);
            chk("idle_busy", rx_busy, 0);
        end
        force_bps = 1'b0;
        tick(5);
        chk("idle_valid", n_valid - v0, 0);
        chk("idle_err", n_err - e0, 0);
        chk("idle_rx_data", rx_data, exp_data);

        // Random frames; an errored frame needs the line high before the next.
        for (int i = 0; i < 5; i++) begin
            d   = DB'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            gap = sb ? int'($urandom_range(0, BPS_FULL))
                     : BPS_FULL + int'($urandom_range(0, 100));
            run_frame(d, sb, gap, "rnd");
        end

        chk("never_both", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
